// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer between the icache and the decoder.
// Owns the fetch PC, holds one instruction until the decoder takes it, stalls
// after control-flow instructions until a redirect arrives, and applies ROB
// flushes with top priority.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    output logic             icache_req,
    output logic [31:0]      icache_addr,
    input  logic             icache_valid,
    input  logic [31:0]      icache_inst,
    input  logic             need_inst,
    output logic             inst_ready,
    output logic [31:0]      inst_out,
    output logic [31:0]      inst_pc,
    input  logic             clear_inst,
    input  logic [31:0]      if_addr,
    input  logic             rob_clear,
    input  logic [31:0]      rob_target_pc,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, WAIT_REDIR} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_inst;
    logic [31:0]      r_inst_pc;
    logic [CNT_W-1:0] r_cnt;
    // One-cycle request gap after a redirect while a fetch was in flight;
    // dropping icache_req is how the cache is told to abandon that fetch.
    logic             r_cancel;
    logic             w_is_cf;

    // jal / jalr / branch: the next PC is unknown until the decoder redirects.
    assign w_is_cf = (r_inst[6:0] == 7'b1101111) ||
                     (r_inst[6:0] == 7'b1100111) ||
                     (r_inst[6:0] == 7'b1100011);

    assign icache_req  = (r_state == REQ) && !r_cancel;
    assign icache_addr = r_pc;
    assign inst_ready  = (r_state == HOLD);
    assign inst_out    = r_inst;
    assign inst_pc     = r_inst_pc;
    assign fetch_count = r_cnt;

    // Sequencer: priority rob_clear > clear_inst > accept > icache_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pc      <= RESET_PC;
            r_inst    <= 32'h0;
            r_inst_pc <= 32'h0;
            r_cnt     <= '0;
            r_cancel  <= 1'b0;
        end else if (rdy) begin
            r_cancel <= 1'b0;
            if (rob_clear) begin
                r_pc     <= rob_target_pc;
                r_state  <= REQ;
                r_cancel <= (r_state == REQ);
            end else begin
                case (r_state)
                    IDLE: r_state <= REQ;
                    REQ: begin
                        if (clear_inst) begin
                            r_pc     <= if_addr;
                            r_cancel <= 1'b1;
                        end else if (icache_valid && !r_cancel) begin
                            r_inst    <= icache_inst;
                            r_inst_pc <= r_pc;
                            r_state   <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (clear_inst) begin
                            r_pc    <= if_addr;
                            r_state <= REQ;
                        end else if (need_inst) begin
                            r_cnt <= r_cnt + CNT_ONE;
                            if (w_is_cf) begin
                                r_state <= WAIT_REDIR;
                            end else begin
                                r_pc    <= r_pc + 32'd4;
                                r_state <= REQ;
                            end
                        end
                    end
                    WAIT_REDIR: begin
                        if (clear_inst) begin
                            r_pc    <= if_addr;
                            r_state <= REQ;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by random traffic, all
// checked every cycle against a flag-based reference model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b0;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_valid = 1'b0;
    logic [31:0] icache_inst = 32'h0;
    logic        need_inst = 1'b0;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        clear_inst = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        rob_clear = 1'b0;
    logic [31:0] rob_target_pc = 32'h0;
    logic [31:0] fetch_count;

    int total = 0;
    int bad = 0;

    fetch_ctrl #(.RESET_PC(32'h0), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .icache_req(icache_req), .icache_addr(icache_addr),
        .icache_valid(icache_valid), .icache_inst(icache_inst),
        .need_inst(need_inst), .inst_ready(inst_ready),
        .inst_out(inst_out), .inst_pc(inst_pc),
        .clear_inst(clear_inst), .if_addr(if_addr),
        .rob_clear(rob_clear), .rob_target_pc(rob_target_pc),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Reference model: what the fetch unit is "doing", as independent flags.
    bit          m_start;   // first enabled cycle after reset not yet seen
    bit          m_have;    // an instruction is offered to the decoder
    bit          m_wait;    // waiting for a redirect after control flow
    bit          m_gap;     // request withheld this cycle (cancel)
    logic [31:0] m_pc, m_inst, m_ipc, m_cnt;

    function automatic bit is_cf(input logic [31:0] w);
        return (w[6:0] == 7'h6f) || (w[6:0] == 7'h67) || (w[6:0] == 7'h63);
    endfunction

    function automatic bit m_req();
        return !m_start && !m_have && !m_wait && !m_gap;
    endfunction

    task automatic m_reset();
        m_start = 1; m_have = 0; m_wait = 0; m_gap = 0;
        m_pc = 32'h0; m_inst = 32'h0; m_ipc = 32'h0; m_cnt = 32'h0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("icache_req", {31'b0, icache_req}, {31'b0, m_req()});
        chk("icache_addr", icache_addr, m_pc);
        chk("inst_ready", {31'b0, inst_ready}, {31'b0, m_have});
        chk("inst_out", inst_out, m_inst);
        chk("inst_pc", inst_pc, m_ipc);
        chk("fetch_count", fetch_count, m_cnt);
    endtask

    // One clock: drive inputs, advance the model, check on the falling edge.
    task automatic cyc(input logic en, input logic v, input logic [31:0] w,
                       input logic nd, input logic clr, input logic [31:0] ia,
                       input logic rob, input logic [31:0] rt);
        bit in_req;
        bit g;
        rdy = en; icache_valid = v; icache_inst = w; need_inst = nd;
        clear_inst = clr; if_addr = ia; rob_clear = rob; rob_target_pc = rt;
        @(posedge clk);
        if (en) begin
            in_req = !m_start && !m_have && !m_wait;
            g = 0;
            if (rob) begin
                m_pc = rt; g = in_req; m_have = 0; m_wait = 0; m_start = 0;
            end else if (m_start) begin
                m_start = 0;
            end else if (clr) begin
                m_pc = ia; g = in_req; m_have = 0; m_wait = 0;
            end else if (m_have) begin
                if (nd) begin
                    m_cnt = m_cnt + 1;
                    m_have = 0;
                    if (is_cf(m_inst)) m_wait = 1;
                    else m_pc = m_pc + 4;
                end
            end else if (in_req && !m_gap && v) begin
                m_inst = w; m_ipc = m_pc; m_have = 1;
            end
            m_gap = g;
        end
        @(negedge clk);
        chk_all();
    endtask

    task automatic idle();
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] pick_inst();
        case ($urandom_range(0, 4))
            0: return 32'h0000_0013;
            1: return 32'h0080_006f;
            2: return 32'h0000_8067;
            3: return 32'h0020_8463;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rdy = 1'b1;
        chk_all();

        // Sequential fetch of three nops, decoder always ready.
        idle();
        chk("first_addr", icache_addr, 32'h0);
        repeat (3) begin
            cyc(1, 1, 32'h13, 0, 0, 0, 0, 0);
            cyc(1, 0, 0, 1, 0, 0, 0, 0);
        end
        chk("count_after_3", fetch_count, 32'd3);
        chk("addr_after_3", icache_addr, 32'hC);

        // Instruction held while decoder is busy.
        cyc(1, 1, 32'h13, 0, 0, 0, 0, 0);
        repeat (5) idle();
        cyc(1, 0, 0, 1, 0, 0, 0, 0);
        chk("addr_after_hold", icache_addr, 32'h10);

        // Flush racing an icache return in REQ.
        cyc(1, 1, 32'h13, 0, 0, 0, 1, 32'h100);
        chk("flush_gap_req", {31'b0, icache_req}, 32'h0);
        idle();
        chk("flush_addr", icache_addr, 32'h100);
        chk("flush_count", fetch_count, 32'd4);

        // jal stalls until the decoder redirects.
        cyc(1, 1, 32'h0080_006f, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, 0);
        repeat (3) idle();
        cyc(1, 0, 0, 0, 1, 32'h28, 0, 0);
        chk("redir_addr", icache_addr, 32'h28);

        // rob_clear beats clear_inst in WAIT_REDIR.
        cyc(1, 1, 32'h0020_8463, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 32'h300, 1, 32'h200);
        chk("rob_wins", icache_addr, 32'h200);

        // Freeze with rdy low, then async reset mid-HOLD.
        cyc(1, 1, 32'h13, 0, 0, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 1, 1, 32'h44, 1, 32'h55);
        chk("frozen_ready", {31'b0, inst_ready}, 32'h1);
        rdy = 1'b1; need_inst = 0; clear_inst = 0; rob_clear = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_ready", {31'b0, inst_ready}, 32'h0);
        chk("async_req", {31'b0, icache_req}, 32'h0);
        chk("async_pc", icache_addr, 32'h0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        chk_all();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        en, v, nd, clr, rob;
            logic [31:0] w, ia, rt;
            en  = ($urandom_range(0, 9) != 0);
            rob = ($urandom_range(0, 19) == 0);
            clr = m_wait ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 24) == 0);
            nd  = $urandom_range(0, 1);
            v   = m_req() && ($urandom_range(0, 2) == 0);
            w   = pick_inst();
            ia  = $urandom;
            rt  = $urandom;
            cyc(en, v, w, nd, clr, ia, rob, rt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
